// File: rtl/sr_pkg.sv
// Shared definitions for the layer serializer: byte width, FSM state encoding and a
// width helper used to size counters.
package sr_pkg;

    localparam int unsigned BYTE_W = 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_PAD   = 2'd2
    } sr_state_e;

    // Bits needed to hold values 0..n-1; never returns less than 1.
    function automatic int unsigned sr_clog2(input int unsigned n);
        int unsigned w;
        w = 1;
        while ((32'd1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/stream_pos_counter.sv
// Column/row position tracker for a raster byte stream. Decodes row and frame ends for both
// the current position and the position after this cycle's increment.
module stream_pos_counter
    import sr_pkg::*;
#(
    parameter int unsigned ROW_LENGTH = 28,
    parameter int unsigned NUM_ROWS   = 28,
    localparam int unsigned COL_W     = sr_clog2(ROW_LENGTH),
    localparam int unsigned ROW_W     = sr_clog2(NUM_ROWS)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inc,
    output logic [COL_W-1:0] col,
    output logic [ROW_W-1:0] row,
    output logic             row_last,
    output logic             frame_last,
    output logic             row_last_nxt,
    output logic             frame_last_nxt
);

    localparam logic [COL_W-1:0] COL_MAX = COL_W'(ROW_LENGTH - 1);
    localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(NUM_ROWS - 1);

    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;

    always_comb begin
        row_last   = (col_q == COL_MAX);
        frame_last = row_last && (row_q == ROW_MAX);
        col_d      = col_q;
        row_d      = row_q;
        if (inc) begin
            if (row_last) begin
                col_d = '0;
                row_d = frame_last ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
        // Lookahead lets a caller register flags for the byte it is about to present.
        row_last_nxt   = (col_d == COL_MAX);
        frame_last_nxt = row_last_nxt && (row_d == ROW_MAX);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    assign col = col_q;
    assign row = row_q;

endmodule

// File: rtl/layer_serializer.sv
// Parallel-in/serial-out byte streamer with row/frame end flags for a line-buffer input.
// Define LAYER_SER_PAD_EN to append PAD_WIDTH zero bytes after every row.
module layer_serializer
    import sr_pkg::*;
#(
    parameter int unsigned NUM_WORDS  = 4,
    parameter int unsigned ROW_LENGTH = 28,
    parameter int unsigned NUM_ROWS   = 28,
    parameter int unsigned PAD_WIDTH  = 1
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [BYTE_W*NUM_WORDS-1:0]   p_in,
    input  logic                          p_in_valid,
    output logic                          p_in_ready,
    output logic [BYTE_W-1:0]             shift_out,
    output logic                          shift_out_valid,
    input  logic                          shift_out_ready,
    output logic                          row_end,
    output logic                          frame_end
);

    localparam int unsigned VEC_W  = BYTE_W * NUM_WORDS;
    localparam int unsigned WORD_W = sr_clog2(NUM_WORDS);
    localparam int unsigned COL_W  = sr_clog2(ROW_LENGTH);
    localparam int unsigned ROW_W  = sr_clog2(NUM_ROWS);
    localparam logic [WORD_W-1:0] WORD_MAX = WORD_W'(NUM_WORDS - 1);

    sr_state_e         state_q, state_d;
    logic [BYTE_W-1:0] shift_q, shift_d;
    logic [VEC_W-1:0]  rest_q, rest_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic              valid_q, valid_d;
    logic              row_end_q, row_end_d;
    logic              frame_end_q, frame_end_d;

    logic              accept;
    logic              last_word;
    logic              take;
    logic              adv;
    logic              cnt_inc;
    logic [COL_W-1:0]  col;
    logic [ROW_W-1:0]  row;
    logic              row_last;
    logic              frame_last;
    logic              row_last_nxt;
    logic              frame_last_nxt;
    logic              unused_pos;

`ifdef LAYER_SER_PAD_EN
    localparam int unsigned PAD_W = sr_clog2(PAD_WIDTH);
    localparam logic [PAD_W-1:0] PAD_MAX = PAD_W'(PAD_WIDTH - 1);

    logic [PAD_W-1:0] pad_q, pad_d;
    logic [PAD_W-1:0] pad_inc;

    assign pad_inc    = pad_q + 1'b1;
    assign unused_pos = ^{col, row_last_nxt, frame_last_nxt};
`else
    assign unused_pos = ^{col, row, row_last, frame_last, PAD_WIDTH};
`endif

    assign accept    = valid_q & shift_out_ready;
    assign last_word = (word_q == WORD_MAX);
    // Position advances only on accepted data bytes, never on pad bytes.
    assign cnt_inc   = accept & (state_q == S_SHIFT);

    stream_pos_counter #(
        .ROW_LENGTH (ROW_LENGTH),
        .NUM_ROWS   (NUM_ROWS)
    ) u_pos (
        .clock          (clock),
        .reset          (reset),
        .inc            (cnt_inc),
        .col            (col),
        .row            (row),
        .row_last       (row_last),
        .frame_last     (frame_last),
        .row_last_nxt   (row_last_nxt),
        .frame_last_nxt (frame_last_nxt)
    );

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        rest_d      = rest_q;
        word_d      = word_q;
        valid_d     = valid_q;
        row_end_d   = row_end_q;
        frame_end_d = frame_end_q;
        p_in_ready  = 1'b0;
        take        = 1'b0;
        adv         = 1'b0;
`ifdef LAYER_SER_PAD_EN
        pad_d       = pad_q;
`endif

        case (state_q)
            S_IDLE: begin
                p_in_ready = 1'b1;
                take       = p_in_valid;
            end
            S_SHIFT: begin
                if (accept) begin
`ifdef LAYER_SER_PAD_EN
                    if (row_last) begin
                        state_d     = S_PAD;
                        pad_d       = '0;
                        shift_d     = '0;
                        row_end_d   = (PAD_MAX == '0);
                        frame_end_d = (PAD_MAX == '0) && frame_last;
                    end else
`endif
                    if (last_word) begin
                        p_in_ready = 1'b1;
                        take       = p_in_valid;
                        if (!p_in_valid) begin
                            valid_d = 1'b0;
                            state_d = S_IDLE;
                        end
                    end else begin
                        adv = 1'b1;
                    end
                end
            end
`ifdef LAYER_SER_PAD_EN
            S_PAD: begin
                if (accept) begin
                    if (pad_q == PAD_MAX) begin
                        // No reload from pad: the next load waits for IDLE.
                        if (last_word) begin
                            valid_d = 1'b0;
                            state_d = S_IDLE;
                        end else begin
                            adv = 1'b1;
                        end
                    end else begin
                        pad_d       = pad_inc;
                        row_end_d   = (pad_inc == PAD_MAX);
                        frame_end_d = (pad_inc == PAD_MAX) && (row == '0);
                    end
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (take || adv) begin
            state_d = S_SHIFT;
            valid_d = 1'b1;
`ifdef LAYER_SER_PAD_EN
            row_end_d   = 1'b0;
            frame_end_d = 1'b0;
`else
            row_end_d   = row_last_nxt;
            frame_end_d = frame_last_nxt;
`endif
        end
        if (take) begin
            shift_d = p_in[BYTE_W-1:0];
            rest_d  = p_in >> BYTE_W;
            word_d  = '0;
        end
        if (adv) begin
            shift_d = rest_q[BYTE_W-1:0];
            rest_d  = rest_q >> BYTE_W;
            word_d  = word_q + 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            shift_q     <= '0;
            rest_q      <= '0;
            word_q      <= '0;
            valid_q     <= 1'b0;
            row_end_q   <= 1'b0;
            frame_end_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            rest_q      <= rest_d;
            word_q      <= word_d;
            valid_q     <= valid_d;
            row_end_q   <= row_end_d;
            frame_end_q <= frame_end_d;
        end
    end

`ifdef LAYER_SER_PAD_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pad_q <= '0;
        end else begin
            pad_q <= pad_d;
        end
    end
`endif

    assign shift_out       = shift_q;
    assign shift_out_valid = valid_q;
    assign row_end         = row_end_q;
    assign frame_end       = frame_end_q;

endmodule

// File: tb/tb_layer_serializer.sv
// Self-checking bench for layer_serializer: directed cases plus randomized traffic checked
// against a queue-based model of the expected byte stream.
module tb_layer_serializer;

    localparam int unsigned NW = 4;
    localparam int unsigned RL = 6;
    localparam int unsigned NR = 2;
    localparam int unsigned PW = 2;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] p_in;
    logic        p_in_valid;
    logic        p_in_ready;
    logic [7:0]  shift_out;
    logic        shift_out_valid;
    logic        shift_out_ready;
    logic        row_end;
    logic        frame_end;

    always #5 clock = ~clock;

    layer_serializer #(
        .NUM_WORDS  (NW),
        .ROW_LENGTH (RL),
        .NUM_ROWS   (NR),
        .PAD_WIDTH  (PW)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .p_in            (p_in),
        .p_in_valid      (p_in_valid),
        .p_in_ready      (p_in_ready),
        .shift_out       (shift_out),
        .shift_out_valid (shift_out_valid),
        .shift_out_ready (shift_out_ready),
        .row_end         (row_end),
        .frame_end       (frame_end)
    );

    typedef struct {
        logic [7:0] b;
        logic       re;
        logic       fe;
        logic       rdy;
    } ent_t;

    typedef struct {
        int         cyc;
        logic [7:0] b;
        logic       re;
        logic       fe;
        logic       rdy;
    } obs_t;

    ent_t exp_q[$];
    obs_t log_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   data_idx = 0;
    bit   zeroed   = 1'b1;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected stream for one load: raster position numbering decides the flags.
    task automatic push_load(input logic [31:0] v);
        for (int k = 0; k < int'(NW); k++) begin
            logic [7:0] b;
            bit re, fe, last;
            b    = v[8*k +: 8];
            re   = (data_idx % RL) == RL - 1;
            fe   = re && ((data_idx / RL) == NR - 1);
            last = (k == NW - 1);
            data_idx = (data_idx + 1) % (RL * NR);
`ifdef LAYER_SER_PAD_EN
            if (re) begin
                exp_q.push_back('{b, 1'b0, 1'b0, 1'b0});
                for (int p = 0; p < int'(PW); p++) begin
                    exp_q.push_back('{8'h00, p == PW - 1, fe && (p == PW - 1), 1'b0});
                end
            end else begin
                exp_q.push_back('{b, 1'b0, 1'b0, last});
            end
`else
            exp_q.push_back('{b, re, fe, last});
`endif
        end
    endtask

    // Compare process: mid-cycle, outputs vs model, then advance model by this cycle's handshakes.
    initial begin
        forever begin
            ent_t f;
            bit ev, er;
            @(negedge clock);
            if (reset) begin
                check("rst_valid", shift_out_valid, 0);
                check("rst_data", shift_out, 0);
                check("rst_row_end", row_end, 0);
                check("rst_frame_end", frame_end, 0);
                exp_q.delete();
                data_idx = 0;
                zeroed   = 1'b1;
            end else begin
                ev = exp_q.size() > 0;
                if (ev) f = exp_q[0];
                check("valid", shift_out_valid, ev);
                if (ev) begin
                    check("data", shift_out, f.b);
                    check("row_end", row_end, f.re);
                    check("frame_end", frame_end, f.fe);
                    log_q.push_back('{cyc, shift_out, row_end, frame_end, p_in_ready});
                end else if (zeroed) begin
                    check("idle_data", shift_out, 0);
                    check("idle_flags", {row_end, frame_end}, 0);
                end
                er = !ev || (f.rdy && shift_out_ready);
                check("p_in_ready", p_in_ready, er);
                if (ev && shift_out_ready) void'(exp_q.pop_front());
                if (p_in_valid && er) begin
                    push_load(p_in);
                    zeroed = 1'b0;
                end
            end
        end
    end

    initial begin
        reset           = 1'b1;
        p_in            = '0;
        p_in_valid      = 1'b0;
        shift_out_ready = 1'b0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;

        // Single load, LSB byte first, then valid drops.
        @(posedge clock); #1;
        log_q.delete();
        p_in            = 32'h44332211;
        p_in_valid      = 1'b1;
        shift_out_ready = 1'b1;
        @(posedge clock); #1 p_in_valid = 1'b0;
        repeat (6) @(posedge clock); #1;
        check("t1_count", log_q.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < log_q.size()) begin
                check("t1_byte", log_q[i].b, 8'h11 * (i + 1));
                check("t1_gap", log_q[i].cyc - log_q[0].cyc, i);
            end
        end

`ifndef LAYER_SER_PAD_EN
        // Three back-to-back loads from position zero: no bubbles, row/frame flags.
        reset = 1'b1;
        @(posedge clock); #1 reset = 1'b0;
        log_q.delete();
        p_in       = 32'h04030201;
        p_in_valid = 1'b1;
        @(posedge clock); #1 p_in = 32'h08070605;
        repeat (4) @(posedge clock); #1 p_in = 32'h0c0b0a09;
        repeat (4) @(posedge clock); #1 p_in_valid = 1'b0;
        repeat (6) @(posedge clock); #1;
        check("t4_count", log_q.size(), 12);
        for (int i = 0; i < 12; i++) begin
            if (i < log_q.size()) begin
                check("t4_byte", log_q[i].b, i + 1);
                check("t4_gap", log_q[i].cyc - log_q[0].cyc, i);
                check("t4_row_end", log_q[i].re, (i == 5) || (i == 11));
                check("t4_frame_end", log_q[i].fe, i == 11);
                check("t2_ready_pulse", log_q[i].rdy, (i % 4) == 3);
            end
        end
`endif

        // Reset in the middle of a load aborts immediately; position restarts at zero.
        p_in       = 32'hddccbbaa;
        p_in_valid = 1'b1;
        @(posedge clock); #1 p_in_valid = 1'b0;
        @(posedge clock); #1 reset = 1'b1;
        #1;
        check("t5_valid", shift_out_valid, 0);
        check("t5_data", shift_out, 0);
        check("t5_flags", {row_end, frame_end}, 0);
        @(posedge clock); #1 reset = 1'b0;
        log_q.delete();
        p_in       = 32'h14131211;
        p_in_valid = 1'b1;
        @(posedge clock); #1 p_in = 32'h18171615;
        repeat (4) @(posedge clock); #1 p_in_valid = 1'b0;
        repeat (8) @(posedge clock); #1;
        if (log_q.size() > 5) begin
            check("t5_first_byte", log_q[0].b, 8'h11);
`ifndef LAYER_SER_PAD_EN
            check("t5_row_end_early", log_q[4].re, 0);
            check("t5_row_end", log_q[5].re, 1);
`endif
        end else begin
            check("t5_count", log_q.size(), 8);
        end

        // Randomized traffic with random backpressure and occasional resets.
        for (int i = 0; i < 4000; i++) begin
            @(posedge clock); #1;
            if ($urandom_range(0, 499) == 0) begin
                reset      = 1'b1;
                p_in_valid = 1'b0;
            end else begin
                reset           = 1'b0;
                p_in_valid      = ($urandom_range(0, 3) != 0);
                p_in            = $urandom;
                shift_out_ready = ($urandom_range(0, 2) != 0);
            end
        end

        @(posedge clock); #1;
        reset           = 1'b0;
        p_in_valid      = 1'b0;
        shift_out_ready = 1'b1;
        repeat (30) @(posedge clock); #1;
        check("drain_model_empty", exp_q.size(), 0);
        check("drain_valid", shift_out_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
